// File: rtl/layer_priority_mux.sv
// Fixed-priority layer compositor: layer 0 wins, one registered cycle of latency,
// plus per-frame overlap statistics. Optional macro LAYER_TRANSPARENT_KEY_EN masks colour-keyed pixels.
module layer_priority_mux #(
  parameter int                NUM_LAYERS  = 4,
  parameter int                RGB_W       = 8,
  parameter int                CNT_W       = 16,
  parameter logic [RGB_W-1:0]  TRANSPARENT = 8'hFF
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_LAYERS-1:0]         drawRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0]   RGBIn,
  input  logic [NUM_LAYERS*4-1:0]       hitEdgeIn,
  input  logic                          startOfFrame,
  output logic                          drawRequestOut,
  output logic [RGB_W-1:0]              RGBOut,
  output logic [3:0]                    HitEdgeCode,
  output logic [$clog2(NUM_LAYERS)-1:0] layerIdOut,
  output logic [NUM_LAYERS-1:0]         overlapMask,
  output logic [CNT_W-1:0]              overlapPixels,
  output logic                          overlapValid
);

  localparam int ID_W = $clog2(NUM_LAYERS);

`ifdef LAYER_TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [RGB_W-1:0]      layer_rgb [NUM_LAYERS];
  logic [3:0]            layer_hit [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] eff;

  // With the key disabled the compare folds away and eff is drawRequest verbatim.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    assign layer_rgb[gi] = RGBIn[gi*RGB_W +: RGB_W];
    assign layer_hit[gi] = hitEdgeIn[gi*4 +: 4];
    assign eff[gi]       = drawRequest[gi] & (~KEY_EN | (layer_rgb[gi] != TRANSPARENT));
  end

  logic             win_found;
  logic [RGB_W-1:0] win_rgb;
  logic [3:0]       win_hit;
  logic [ID_W-1:0]  win_id;

  // Scan from the lowest priority upward so the lowest active index is written last.
  always_comb begin
    win_found = 1'b0;
    win_rgb   = '0;
    win_hit   = '0;
    win_id    = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        win_found = 1'b1;
        win_rgb   = layer_rgb[i];
        win_hit   = layer_hit[i];
        win_id    = ID_W'(i);
      end
    end
  end

  // Two or more bits set exactly when clearing the lowest set bit leaves something.
  logic overlap_pix;
  assign overlap_pix = |(eff & (eff - NUM_LAYERS'(1)));

  logic                  draw_q,      draw_d;
  logic [RGB_W-1:0]      rgb_q,       rgb_d;
  logic [3:0]            hit_q,       hit_d;
  logic [ID_W-1:0]       id_q,        id_d;
  logic [NUM_LAYERS-1:0] acc_mask_q,  acc_mask_d;
  logic [CNT_W-1:0]      acc_cnt_q,   acc_cnt_d;
  logic [NUM_LAYERS-1:0] ovl_mask_q,  ovl_mask_d;
  logic [CNT_W-1:0]      ovl_cnt_q,   ovl_cnt_d;
  logic                  ovl_valid_q, ovl_valid_d;

  always_comb begin
    draw_d = win_found;
    rgb_d  = win_rgb;
    hit_d  = win_hit;
    id_d   = win_id;
  end

  logic [CNT_W-1:0] acc_cnt_inc;
  assign acc_cnt_inc = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);

  // The start-of-frame pixel publishes the closed frame and seeds the new one.
  always_comb begin
    acc_mask_d  = acc_mask_q;
    acc_cnt_d   = acc_cnt_q;
    ovl_mask_d  = ovl_mask_q;
    ovl_cnt_d   = ovl_cnt_q;
    ovl_valid_d = startOfFrame;
    if (startOfFrame) begin
      ovl_mask_d = acc_mask_q;
      ovl_cnt_d  = acc_cnt_q;
      acc_mask_d = overlap_pix ? eff : '0;
      acc_cnt_d  = overlap_pix ? CNT_W'(1) : '0;
    end else if (overlap_pix) begin
      acc_mask_d = acc_mask_q | eff;
      acc_cnt_d  = acc_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q      <= 1'b0;
      rgb_q       <= '0;
      hit_q       <= '0;
      id_q        <= '0;
      acc_mask_q  <= '0;
      acc_cnt_q   <= '0;
      ovl_mask_q  <= '0;
      ovl_cnt_q   <= '0;
      ovl_valid_q <= 1'b0;
    end else begin
      draw_q      <= draw_d;
      rgb_q       <= rgb_d;
      hit_q       <= hit_d;
      id_q        <= id_d;
      acc_mask_q  <= acc_mask_d;
      acc_cnt_q   <= acc_cnt_d;
      ovl_mask_q  <= ovl_mask_d;
      ovl_cnt_q   <= ovl_cnt_d;
      ovl_valid_q <= ovl_valid_d;
    end
  end

  assign drawRequestOut = draw_q;
  assign RGBOut         = rgb_q;
  assign HitEdgeCode    = hit_q;
  assign layerIdOut     = id_q;
  assign overlapMask    = ovl_mask_q;
  assign overlapPixels  = ovl_cnt_q;
  assign overlapValid   = ovl_valid_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// Randomized and directed bench for layer_priority_mux against a per-pixel reference model.
// A second instance with a 4-bit counter covers saturation.
module tb_layer_priority_mux;
  localparam int NL  = 4;
  localparam int RW  = 8;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic clk = 1'b0;
  logic resetN;
  logic [NL-1:0]    drawRequest;
  logic [NL*RW-1:0] RGBIn;
  logic [NL*4-1:0]  hitEdgeIn;
  logic             startOfFrame;

  logic           d_draw, s_draw;
  logic [RW-1:0]  d_rgb, s_rgb;
  logic [3:0]     d_hit, s_hit;
  logic [1:0]     d_id, s_id;
  logic [NL-1:0]  d_mask, s_mask;
  logic [CW-1:0]  d_pix;
  logic [CWS-1:0] s_pix;
  logic           d_valid, s_valid;

  layer_priority_mux #(.NUM_LAYERS(NL), .RGB_W(RW), .CNT_W(CW), .TRANSPARENT(8'hFF)) u_dut (
    .clk(clk), .resetN(resetN), .drawRequest(drawRequest), .RGBIn(RGBIn),
    .hitEdgeIn(hitEdgeIn), .startOfFrame(startOfFrame),
    .drawRequestOut(d_draw), .RGBOut(d_rgb), .HitEdgeCode(d_hit), .layerIdOut(d_id),
    .overlapMask(d_mask), .overlapPixels(d_pix), .overlapValid(d_valid));

  layer_priority_mux #(.NUM_LAYERS(NL), .RGB_W(RW), .CNT_W(CWS), .TRANSPARENT(8'hFF)) u_dut_sat (
    .clk(clk), .resetN(resetN), .drawRequest(drawRequest), .RGBIn(RGBIn),
    .hitEdgeIn(hitEdgeIn), .startOfFrame(startOfFrame),
    .drawRequestOut(s_draw), .RGBOut(s_rgb), .HitEdgeCode(s_hit), .layerIdOut(s_id),
    .overlapMask(s_mask), .overlapPixels(s_pix), .overlapValid(s_valid));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected registered outputs plus the running frame totals.
  logic          exp_draw;
  logic [RW-1:0] exp_rgb;
  logic [3:0]    exp_hit;
  logic [1:0]    exp_id;
  logic [NL-1:0] exp_mask;
  int            exp_pix;
  logic          exp_valid;
  logic [NL-1:0] acc_mask;
  int            acc_cnt;

  function automatic int sat(input int v, input int bits);
    int lim;
    lim = (1 << bits) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    exp_draw = 1'b0; exp_rgb = '0; exp_hit = '0; exp_id = '0;
    exp_mask = '0; exp_pix = 0; exp_valid = 1'b0;
    acc_mask = '0; acc_cnt = 0;
  endtask

  task automatic model_cycle();
    int cnt;
    int win;
    logic [NL-1:0] e;
    logic [RW-1:0] c;
    win = -1;
    cnt = 0;
    e   = '0;
    for (int i = 0; i < NL; i++) begin
      c    = RGBIn[i*RW +: RW];
      e[i] = drawRequest[i];
`ifdef LAYER_TRANSPARENT_KEY_EN
      if (c == 8'hFF) e[i] = 1'b0;
`endif
      if (e[i]) begin
        cnt++;
        if (win < 0) win = i;
      end
    end
    if (win >= 0) begin
      exp_draw = 1'b1;
      exp_rgb  = RGBIn[win*RW +: RW];
      exp_hit  = hitEdgeIn[win*4 +: 4];
      exp_id   = 2'(win);
    end else begin
      exp_draw = 1'b0; exp_rgb = '0; exp_hit = '0; exp_id = '0;
    end
    exp_valid = startOfFrame;
    if (startOfFrame) begin
      exp_mask = acc_mask;
      exp_pix  = acc_cnt;
      acc_mask = '0;
      acc_cnt  = 0;
    end
    if (cnt >= 2) begin
      acc_mask = acc_mask | e;
      acc_cnt  = acc_cnt + 1;
    end
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, "_draw"},   32'(d_draw),  32'(exp_draw));
    check({pfx, "_rgb"},    32'(d_rgb),   32'(exp_rgb));
    check({pfx, "_hit"},    32'(d_hit),   32'(exp_hit));
    check({pfx, "_id"},     32'(d_id),    32'(exp_id));
    check({pfx, "_mask"},   32'(d_mask),  32'(exp_mask));
    check({pfx, "_pix"},    32'(d_pix),   32'(sat(exp_pix, CW)));
    check({pfx, "_valid"},  32'(d_valid), 32'(exp_valid));
    check({pfx, "_s_rgb"},  32'(s_rgb),   32'(exp_rgb));
    check({pfx, "_s_mask"}, 32'(s_mask),  32'(exp_mask));
    check({pfx, "_s_pix"},  32'(s_pix),   32'(sat(exp_pix, CWS)));
    check({pfx, "_s_val"},  32'(s_valid), 32'(exp_valid));
  endtask

  task automatic step(input logic [NL-1:0] req, input logic [NL*RW-1:0] rgb,
                      input logic [NL*4-1:0] hit, input logic sof);
    @(negedge clk);
    drawRequest  = req;
    RGBIn        = rgb;
    hitEdgeIn    = hit;
    startOfFrame = sof;
    model_cycle();
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d req=%b sof=%b -> draw=%b rgb=%h id=%0d mask=%b pix=%0d valid=%b",
             txn, req, sof, d_draw, d_rgb, d_id, d_mask, d_pix, d_valid);
    compare_all("cyc");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drawRequest = '0; RGBIn = '0; hitEdgeIn = '0; startOfFrame = 1'b0;
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic logic [NL*RW-1:0] rand_rgb();
    logic [NL*RW-1:0] v;
    for (int i = 0; i < NL; i++)
      v[i*RW +: RW] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    return v;
  endfunction

  localparam logic [NL*RW-1:0] ZRGB = '0;
  localparam logic [NL*4-1:0]  ZHIT = '0;

  initial begin
    logic prev_sof;
    logic sof;
    resetN = 1'b0;
    drawRequest = '0; RGBIn = '0; hitEdgeIn = '0; startOfFrame = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Priority: layer 1 beats layer 3
    step(4'b1010, {8'hE0, 8'h00, 8'h1C, 8'h00}, {4'hA, 4'h0, 4'h5, 4'h0}, 1'b0);
    check("prio_rgb", 32'(d_rgb), 32'h1C);
    check("prio_id",  32'(d_id),  32'd1);
    check("prio_hit", 32'(d_hit), 32'h5);

    // Idle
    step(4'b0000, {8'h11, 8'h22, 8'h33, 8'h44}, 16'hFFFF, 1'b0);
    check("idle_draw", 32'(d_draw), 32'd0);
    check("idle_rgb",  32'(d_rgb),  32'd0);

    // Overlap window: 5 overlap pixels, 3 single-layer pixels
    step(4'b0000, ZRGB, ZHIT, 1'b1);
    repeat (5) step(4'b0011, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b0);
    repeat (3) step(4'b0100, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b0);
    check("ovl_pre_valid", 32'(d_valid), 32'd0);
    step(4'b0000, ZRGB, ZHIT, 1'b1);
    check("ovl_mask",  32'(d_mask),  32'b0011);
    check("ovl_pix",   32'(d_pix),   32'd5);
    check("ovl_valid", 32'(d_valid), 32'd1);
    step(4'b0000, ZRGB, ZHIT, 1'b0);
    check("ovl_valid_drop", 32'(d_valid), 32'd0);
    check("ovl_hold_pix",   32'(d_pix),   32'd5);

    // Saturation of the narrow counter
    repeat (20) step(4'b0011, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b0);
    step(4'b0000, ZRGB, ZHIT, 1'b1);
    check("sat_narrow", 32'(s_pix), 32'hF);
    check("sat_wide",   32'(d_pix), 32'd20);

    // Back-to-back frame pulses: the second publishes only its opening pixel
    step(4'b0110, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b1);
    step(4'b0000, ZRGB, ZHIT, 1'b1);
    check("b2b_mask", 32'(d_mask), 32'b0110);
    check("b2b_pix",  32'(d_pix),  32'd1);

    // Colour key: transparent layer 0 falls through to layer 1
    step(4'b0011, {8'h00, 8'h00, 8'h03, 8'hFF}, ZHIT, 1'b1);
`ifdef LAYER_TRANSPARENT_KEY_EN
    check("key_rgb", 32'(d_rgb), 32'h03);
    check("key_id",  32'(d_id),  32'd1);
`else
    check("key_rgb", 32'(d_rgb), 32'hFF);
    check("key_id",  32'(d_id),  32'd0);
`endif
    step(4'b0000, ZRGB, ZHIT, 1'b1);
`ifdef LAYER_TRANSPARENT_KEY_EN
    check("key_pix", 32'(d_pix), 32'd0);
`else
    check("key_pix", 32'(d_pix), 32'd1);
`endif

    // Reset mid-frame discards the partial frame
    repeat (3) step(4'b0011, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b0);
    pulse_reset();
    repeat (2) step(4'b0011, {8'h01, 8'h02, 8'h03, 8'h04}, ZHIT, 1'b0);
    step(4'b0000, ZRGB, ZHIT, 1'b1);
    check("rst_mid_pix",  32'(d_pix),  32'd2);
    check("rst_mid_mask", 32'(d_mask), 32'b0011);

    // Random traffic with occasional frame pulses and resets
    prev_sof = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      sof = prev_sof ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      step(4'($urandom), rand_rgb(), 16'($urandom), sof);
      prev_sof = sof;
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
        prev_sof = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_priority_mux.md
LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of draw layers; legal range 2..16.
REQ-002 SHALL have parameter RGB_W, default 8, RGB width per layer.
REQ-003 SHALL have parameter CNT_W, default 16, width of the overlap pixel counter.
REQ-004 SHALL have parameter TRANSPARENT, default 8'hFF, the transparent colour key (RGB_W bits).
REQ-005 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port resetN, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port drawRequest, input, NUM_LAYERS, per-layer draw request; bit i belongs to layer i.
REQ-008 SHALL have port RGBIn, input, NUM_LAYERS*RGB_W, per-layer colour; layer i is in bits [i*RGB_W +: RGB_W].
REQ-009 SHALL have port hitEdgeIn, input, NUM_LAYERS*4, per-layer hit-edge code; layer i is in bits [i*4 +: 4].
REQ-010 SHALL have port startOfFrame, input, 1, single-cycle pulse marking the first pixel of a frame.
REQ-011 SHALL have port drawRequestOut, output, 1, registered: any layer is drawing.
REQ-012 SHALL have port RGBOut, output, RGB_W, registered colour of the winning layer.
REQ-013 SHALL have port HitEdgeCode, output, 4, registered hit-edge code of the winning layer.
REQ-014 SHALL have port layerIdOut, output, $clog2(NUM_LAYERS), registered index of the winning layer.
REQ-015 SHALL have port overlapMask, output, NUM_LAYERS, per-layer overlap flags for the previous frame.
REQ-016 SHALL have port overlapPixels, output, CNT_W, count of overlap pixels in the previous frame.
REQ-017 SHALL have port overlapValid, output, 1, one-cycle pulse when overlapMask and overlapPixels update.

Function
REQ-018 SHALL form an effective request vector eff[i], equal to drawRequest[i] in the base build (see REQ-032).
REQ-019 SHALL apply fixed priority: the lowest eff index wins; layer 0 is the highest priority.
REQ-020 SHALL register, one cycle after the inputs are sampled, drawRequestOut=1 and the winner's RGB, hitEdge and index.
REQ-021 SHALL, when eff is all zero, register drawRequestOut=0, RGBOut=0, HitEdgeCode=0 and layerIdOut=0.
REQ-022 SHALL treat a pixel as an overlap pixel when popcount(eff) >= 2.
REQ-023 SHALL OR eff into an internal accumulator accMask on every overlap pixel.
REQ-024 SHALL increment an internal counter accCnt on every overlap pixel; accCnt saturates at all-ones and never wraps.
REQ-025 SHALL, on a cycle with startOfFrame=1: copy accMask to overlapMask and accCnt to overlapPixels; pulse overlapValid=1 in the following cycle; restart accMask and accCnt from that cycle's own overlap contribution (0 if none).
REQ-026 SHALL count the startOfFrame pixel in the new frame, never in the closing frame.
REQ-027 SHALL hold overlapMask and overlapPixels stable between startOfFrame pulses.
REQ-028 SHALL, on back-to-back startOfFrame pulses, publish each one; the second publishes only the single-cycle contribution.
REQ-029 SHALL leave the draw path (REQ-019..021) independent of frame state, with a fixed 1-cycle latency.

Reset
REQ-030 SHALL, while resetN=0, force all outputs, accMask and accCnt to 0, regardless of clk.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; the first startOfFrame after reset publishes only data accumulated since reset release.

Configuration
REQ-032 SHALL, with macro LAYER_TRANSPARENT_KEY_EN defined, set eff[i] = drawRequest[i] AND (RGB of layer i != TRANSPARENT); transparent pixels fall through to lower-priority layers and do not count toward overlap.
REQ-033 SHALL, without LAYER_TRANSPARENT_KEY_EN, set eff = drawRequest and pass TRANSPARENT-valued RGB through unchanged.

Verification
REQ-034 SHALL cover priority: drawRequest=4'b1010, layer1 RGB=8'h1C, layer3 RGB=8'hE0 -> next cycle RGBOut=8'h1C, layerIdOut=1, HitEdgeCode=layer1 code.
REQ-035 SHALL cover idle: drawRequest=0 -> next cycle drawRequestOut=0, RGBOut=0, HitEdgeCode=0.
REQ-036 SHALL cover overlap: 5 cycles of 4'b0011 then 3 cycles of 4'b0100, then startOfFrame -> overlapMask=4'b0011, overlapPixels=5, overlapValid high exactly 1 cycle later.
REQ-037 SHALL cover saturation: CNT_W=4 with 20 overlap pixels, then startOfFrame -> overlapPixels=4'hF.
REQ-038 SHALL cover the macro: with LAYER_TRANSPARENT_KEY_EN defined, drawRequest=4'b0011, layer0 RGB=8'hFF, layer1 RGB=8'h03 -> RGBOut=8'h03, layerIdOut=1, no overlap counted; without the macro -> RGBOut=8'hFF, overlap counted.
REQ-039 SHALL cover mid-frame reset: 3 overlap pixels, reset pulse, 2 overlap pixels, startOfFrame -> overlapPixels=2.
